// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// default operand width and the iteration-counter width helper.
package seq_divider_pkg;

   localparam int DEF_WIDTH = 16;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_DVD  = 3'd1;
   localparam logic [2:0] ST_DVS  = 3'd2;
   localparam logic [2:0] ST_INIT = 3'd3;
   localparam logic [2:0] ST_ITER = 3'd4;
   localparam logic [2:0] ST_FIX  = 3'd5;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      DVD  = ST_DVD,
      DVS  = ST_DVS,
      INIT = ST_INIT,
      ITER = ST_ITER,
      FIX  = ST_FIX
   } state_t;

   // Counter must hold the value WIDTH itself, hence WIDTH+1.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/seq_divider_datapath.sv
// Datapath of the signed divider: operand capture, restoring-division
// registers (A, Q, M, count), sign fix-up and the registered results.
module seq_divider_datapath
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_dvd,
   input  logic             load_dvs,
   input  logic             init,
   input  logic             step,
   input  logic             fix,
   input  logic [WIDTH-1:0] data_in,
   output logic             divisor_zero,
   output logic             is_count_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = cnt_width(WIDTH);

   logic [WIDTH-1:0] dvd_r;
   logic [WIDTH-1:0] dvs_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] m_r;
   logic [CW-1:0]    count_r;
   logic             sign_q_r;
   logic             sign_r_r;

   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH:0]   a_sh;
   logic [WIDTH:0]   t;
   logic             t_neg;
   logic [CW-1:0]    count_dec;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   // The most negative value negates to itself and reads as its unsigned magnitude.
   assign dvd_mag = dvd_r[WIDTH-1] ? -dvd_r : dvd_r;
   assign dvs_mag = dvs_r[WIDTH-1] ? -dvs_r : dvs_r;

   assign a_sh      = {a_r, q_r[WIDTH-1]};
   assign t         = a_sh - {1'b0, m_r};
   assign t_neg     = t[WIDTH];
   assign count_dec = count_r - CW'(1);

   assign divisor_zero  = (dvs_r == {WIDTH{1'b0}});
   assign is_count_zero = (count_dec == {CW{1'b0}});

   assign q_fix = sign_q_r ? -q_r : q_r;
   assign r_fix = sign_r_r ? -a_r : a_r;

   // Operand capture from the shared bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd_r <= {WIDTH{1'b0}};
         dvs_r <= {WIDTH{1'b0}};
      end else begin
         if (load_dvd) begin
            dvd_r <= data_in;
         end
         if (load_dvs) begin
            dvs_r <= data_in;
         end
      end
   end

   // Restoring-division iteration registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r      <= {WIDTH{1'b0}};
         q_r      <= {WIDTH{1'b0}};
         m_r      <= {WIDTH{1'b0}};
         count_r  <= {CW{1'b0}};
         sign_q_r <= 1'b0;
         sign_r_r <= 1'b0;
      end else if (init) begin
         a_r      <= {WIDTH{1'b0}};
         q_r      <= dvd_mag;
         m_r      <= dvs_mag;
         count_r  <= CW'(WIDTH);
         sign_q_r <= dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1];
         sign_r_r <= dvd_r[WIDTH-1];
      end else if (step) begin
         // A stays below M, so the restored value never loses its top bit.
         a_r     <= t_neg ? a_sh[WIDTH-1:0] : t[WIDTH-1:0];
         q_r     <= {q_r[WIDTH-2:0], ~t_neg};
         count_r <= count_dec;
      end
   end

   // Result registers, written only in FIX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quotient    <= {WIDTH{1'b0}};
         remainder   <= {WIDTH{1'b0}};
         div_by_zero <= 1'b0;
      end else if (fix) begin
         if (divisor_zero) begin
            quotient    <= {WIDTH{1'b1}};
            remainder   <= dvd_r;
            div_by_zero <= 1'b1;
         end else begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider (truncating quotient, remainder follows the
// dividend's sign); FSM here, arithmetic in seq_divider_datapath.
module seq_signed_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   state_t state;
   state_t state_nx;

   logic load_dvd;
   logic load_dvs;
   logic init;
   logic step;
   logic fix;
   logic divisor_zero;
   logic is_count_zero;

   assign busy = (state != IDLE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Completion pulse, raised on the edge that leaves FIX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done <= 1'b0;
      end else begin
         done <= (state == FIX);
      end
   end

   // Next-state logic and datapath strobes.
   always_comb begin
      state_nx = state;
      load_dvd = 1'b0;
      load_dvs = 1'b0;
      init     = 1'b0;
      step     = 1'b0;
      fix      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = DVD;
            end else begin
               state_nx = IDLE;
            end
         end
         DVD: begin
            load_dvd = 1'b1;
            state_nx = DVS;
         end
         DVS: begin
            load_dvs = 1'b1;
            state_nx = INIT;
         end
         INIT: begin
            init = 1'b1;
            if (divisor_zero) begin
               state_nx = FIX;
            end else begin
               state_nx = ITER;
            end
         end
         ITER: begin
            step = 1'b1;
            if (is_count_zero) begin
               state_nx = FIX;
            end else begin
               state_nx = ITER;
            end
         end
         FIX: begin
            fix      = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   seq_divider_datapath #(
      .WIDTH(WIDTH)
   ) u_datapath (
      .clk          (clk),
      .rst          (rst),
      .load_dvd     (load_dvd),
      .load_dvs     (load_dvs),
      .init         (init),
      .step         (step),
      .fix          (fix),
      .data_in      (data_in),
      .divisor_zero (divisor_zero),
      .is_count_zero(is_count_zero),
      .quotient     (quotient),
      .remainder    (remainder),
      .div_by_zero  (div_by_zero)
   );

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider: directed operand pairs push expected
// results; a monitor compares them whenever done pulses.
module tb_seq_signed_divider;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] data_in;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int compared = 0;
   int fails    = 0;
   int cyc      = 0;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        z;
      int          lat;
      int          e0;
   } exp_t;

   exp_t sb[$];

   seq_signed_divider #(.WIDTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .data_in    (data_in),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            compared++;
            fails++;
            $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_by_zero", div_by_zero, e.z);
            check("latency", cyc - e.e0, e.lat);
         end
      end
   end

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit chk,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic ez, input int elat);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         compared++;
         fails++;
         $display("FAIL idle_wait: got busy=1 expected busy=0 within 60 cycles");
      end
      start   = 1'b1;
      data_in = a;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (chk) sb.push_back('{q: eq, r: er, z: ez, lat: elat, e0: cyc});
      @(posedge clk);
      #1;
      data_in = b;
      @(posedge clk);
      #1;
      data_in = 16'h0000;
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         compared++;
         fails++;
         $display("FAIL %s_timeout: got no done expected done within 40 cycles", tag);
      end
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      data_in = 16'h0000;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_q", quotient, 16'h0000);
      check("reset_r", remainder, 16'h0000);
      check("reset_z", div_by_zero, 1'b0);
      rst = 1'b0;

      issue(16'd14,   16'hFFF0, 1'b1, 16'h0000, 16'h000E, 1'b0, 20);
      issue(16'd100,  16'd7,    1'b1, 16'h000E, 16'h0002, 1'b0, 20);
      issue(16'hFF9C, 16'd7,    1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 20);
      issue(16'd100,  16'hFFF9, 1'b1, 16'hFFF2, 16'h0002, 1'b0, 20);
      issue(16'd55,   16'd0,    1'b1, 16'hFFFF, 16'h0037, 1'b1, 4);
      issue(16'd9,    16'd3,    1'b1, 16'h0003, 16'h0000, 1'b0, 20);
      issue(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 20);
      issue(16'h8000, 16'd2,    1'b1, 16'hC000, 16'h0000, 1'b0, 20);
      wait_done("last_directed");

      // Abort after eight ITER steps; results from the previous op are nonzero.
      issue(16'd2000, 16'd3, 1'b0, 16'h0000, 16'h0000, 1'b0, 0);
      repeat (9) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midreset_busy", busy, 1'b0);
      check("midreset_done", done, 1'b0);
      check("midreset_q", quotient, 16'h0000);
      check("midreset_r", remainder, 16'h0000);
      check("midreset_z", div_by_zero, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      issue(16'd1000, 16'd10, 1'b1, 16'h0064, 16'h0000, 1'b0, 20);
      wait_done("after_reset");

      // start held high: ignored while busy, re-accepted in the done cycle.
      @(negedge clk);
      start   = 1'b1;
      data_in = 16'd7;
      @(posedge clk);
      #1;
      sb.push_back('{q: 16'h0003, r: 16'h0001, z: 1'b0, lat: 20, e0: cyc});
      @(posedge clk);
      #1;
      data_in = 16'd2;
      @(posedge clk);
      #1;
      wait_done("held_start");
      data_in = 16'hFFF9;
      @(posedge clk);
      #1;
      check("b2b_busy", busy, 1'b1);
      sb.push_back('{q: 16'hFFFD, r: 16'hFFFF, z: 1'b0, lat: 20, e0: cyc});
      start = 1'b0;
      @(posedge clk);
      #1;
      data_in = 16'd2;
      @(posedge clk);
      #1;
      data_in = 16'h0000;
      wait_done("b2b");

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
      $finish;
   end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Sequential signed integer divider; the inverse-operation companion to the team's Booth multiplier.
- Uses the same single-bus operand protocol: one `start` pulse, then operands presented on `data_in` on consecutive cycles. Dividend comes first, then divisor.
- Uses restoring division on magnitudes, one quotient bit per clock, then a sign fix-up.
- Results follow Verilog `/` and `%` semantics: truncating quotient, remainder takes the dividend's sign.

Parameters:
- WIDTH, 16, operand, quotient and remainder width in bits (two's complement).

Ports:
- clk  input  1  system clock, rising edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- data_in  input  WIDTH  operand bus; dividend, then divisor, on the two cycles after start is accepted.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; quotient/remainder/div_by_zero are valid from this cycle onward.
- quotient  output  WIDTH  signed quotient; held until the next FIX.
- remainder  output  WIDTH  signed remainder; held until the next FIX.
- div_by_zero  output  1  set when the divisor was 0; held with the results.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset, including mid-operation:
  - State goes to IDLE immediately.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - All internal registers (A, Q, M, count, sign flags) are cleared.
  - The in-flight operation is discarded; the next start is accepted normally.
- States: IDLE, DVD, DVS, INIT, ITER, FIX. Edges are numbered from E0, the edge where start is accepted.
  - E0, IDLE with start=1 -> DVD. Otherwise stay in IDLE.
  - E1, DVD: dividend register <= data_in -> DVS.
  - E2, DVS: divisor register <= data_in -> INIT.
  - E3, INIT:
    - Load A=0, Q=|dividend|, M=|divisor| (all WIDTH-bit unsigned).
    - count=WIDTH; latch sign_q = dividend[MSB] xor divisor[MSB] and sign_r = dividend[MSB].
    - If divisor==0 -> FIX, else -> ITER.
  - E4..E(3+WIDTH), ITER, one step per edge:
    - Shift {A,Q} left by 1 and form T = A_shifted - M, using WIDTH+1 bits.
    - If T >= 0: A=T and Q[0]=1. Otherwise A is kept (restore) and Q[0]=0.
    - count decrements. The edge with count==1 goes -> FIX.
  - FIX, normal case:
    - quotient <= sign_q ? -Q : Q.
    - remainder <= sign_r ? -A : A.
    - div_by_zero <= 0.
  - FIX, divisor zero:
    - quotient <= all ones.
    - remainder <= dividend.
    - div_by_zero <= 1.
  - FIX always: done <= 1 -> IDLE. done clears on the following edge.
- Latency from E0 to the done pulse:
  - Normal: done is high in the cycle after E(4+WIDTH), i.e. edge 20 for WIDTH=16.
  - Divide by zero: done is high after E4.
- |x| is computed in WIDTH bits. The most negative value stays 0x8000 and is treated as unsigned 32768, which is correct magnitude-wise.
- Overflow: -32768 / -1 gives quotient 0x8000 (two's-complement wrap), remainder 0, no flag.
- Handshake edges:
  - start is ignored while busy=1.
  - start in the done cycle is accepted, since the state is already IDLE; back-to-back operations are legal.
  - data_in is don't-care outside DVD and DVS.
- Outputs are registered and change only at FIX or reset.

Decomposition:
- Package seq_divider_pkg holds:
  - The state encoding localparams (IDLE..FIX, 3 bits).
  - The WIDTH default.
  - The count width, clog2(WIDTH+1).
- One sub-module, seq_divider_datapath, following the team's controlpath/datapath split:
  - Contains the A/Q/M/count registers, the subtractor, magnitude and negate logic.
  - Drives status bits isCountZero and T_neg.
- The FSM lives in the top, seq_signed_divider, and drives datapath load/shift/decrement strobes.

Test Plan:
- 14 / -16 (the Booth bench's operands): quotient 0, remainder 14, div_by_zero 0, done at edge 20 after start.
- 100 / 7 -> q 14, r 2; -100 / 7 -> q 0xFFF2 (-14), r 0xFFFE (-2); 100 / -7 -> q -14, r 2.
- 55 / 0 -> div_by_zero 1, q 0xFFFF, r 55, done at edge 4; next op 9 / 3 -> flag 0, q 3, r 0.
- -32768 / -1 -> q 0x8000, r 0; -32768 / 2 -> q 0xC000, r 0.
- Reset pulse during ITER (after 8 steps): outputs 0 and busy 0 immediately, before the next clk edge; then 1000 / 10 -> q 100, r 0.
- start held high throughout: no re-trigger while busy; start in the done cycle begins the next operation, with busy high from the next edge.
